// File: rtl/jtvigil_romarb.sv
// SDRAM read arbiter: up to eight ROM slots share one bank read port.
// Each slot holds a one-entry cache (tag/valid/data) so repeated reads hit without SDRAM traffic.
module jtvigil_romarb #(
    parameter int                  SLOTS  = 4,
    parameter int                  AW     = 18,
    parameter int                  DW     = 8,
    parameter int                  RR     = 1,
    parameter logic [SLOTS*22-1:0] OFFSET = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SLOTS-1:0]      slot_cs,
    input  logic [SLOTS*AW-1:0]   slot_addr,
    output logic [SLOTS-1:0]      slot_ok,
    output logic [SLOTS*DW-1:0]   slot_data,
    output logic [21:0]           ba_addr,
    output logic                  ba_rd,
    input  logic                  ba_ack,
    input  logic                  ba_dst,
    input  logic                  ba_dok,
    input  logic                  ba_rdy,
    input  logic [15:0]           data_read
);
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

    state_t        state_reg, state_next;
    logic [SW-1:0] cur_reg, cur_next;
    logic [SW-1:0] last_reg, last_next;
    logic [AW-1:0] req_addr_reg, req_addr_next;
    logic [21:0]   ba_addr_reg, ba_addr_next;
    logic          ba_rd_reg, ba_rd_next;
    logic [1:0]    wcnt_reg, wcnt_next;

    logic [AW-1:0]    addr_arr  [SLOTS];
    logic [21:0]      waddr_arr [SLOTS];
    logic [SLOTS-1:0] need;
    logic [SW-1:0]    gnt;
    logic             gnt_any;
    logic             ack_evt, dok_evt, rdy_evt;
    logic [1:0]       word_idx;

    assign ack_evt  = (state_reg == REQ) && ba_ack;
    assign dok_evt  = (state_reg == DATA) && ba_dok;
    assign rdy_evt  = (state_reg == DATA) && ba_rdy;
    // ba_dst marks the next word as word 0, including a word arriving in the same cycle
    assign word_idx = ba_dst ? 2'd0 : wcnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            logic [AW-1:0] tag_reg;
            logic          valid_reg;
            logic [DW-1:0] dbuf_reg;
            logic [DW-1:0] store_val;
            logic          store_en;
            logic          sel;

            assign addr_arr[gi]            = slot_addr[gi*AW +: AW];
            assign slot_ok[gi]             = slot_cs[gi] & valid_reg & (addr_arr[gi] == tag_reg);
            assign slot_data[gi*DW +: DW]  = dbuf_reg;
            assign sel                     = (cur_reg == SW'(gi));
            assign need[gi]                = slot_cs[gi] & ~slot_ok[gi] & ~((state_reg != IDLE) && sel);

            if (DW == 8) begin : g_w8
                assign waddr_arr[gi] = OFFSET[gi*22 +: 22] + 22'(addr_arr[gi] >> 1);
                assign store_val     = tag_reg[0] ? data_read[15:8] : data_read[7:0];
                assign store_en      = (word_idx == 2'd0);
            end else if (DW == 16) begin : g_w16
                assign waddr_arr[gi] = OFFSET[gi*22 +: 22] + 22'(addr_arr[gi]);
                assign store_val     = data_read;
                assign store_en      = (word_idx == 2'd0);
            end else begin : g_w32
                assign waddr_arr[gi] = OFFSET[gi*22 +: 22] + 22'({addr_arr[gi], 1'b0});
                assign store_val     = (word_idx == 2'd0) ? {dbuf_reg[DW-1 -: 16], data_read}
                                                          : {data_read, dbuf_reg[15:0]};
                assign store_en      = ~word_idx[1];
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    tag_reg   <= '0;
                    valid_reg <= 1'b0;
                    dbuf_reg  <= '0;
                end else if (sel) begin
                    if (ack_evt) begin
                        tag_reg   <= req_addr_reg;
                        valid_reg <= 1'b0;
                    end
                    if (dok_evt && store_en) begin
                        dbuf_reg <= store_val;
                    end
                    if (rdy_evt) begin
                        valid_reg <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Round-robin starts searching just after the last grant; fixed priority always from slot 0
    always_comb begin
        int idx;
        gnt     = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 0; k < SLOTS; k++) begin
            idx = (RR != 0) ? ((int'(last_reg) + 1 + k) % SLOTS) : k;
            if (!gnt_any && need[SW'(idx)]) begin
                gnt_any = 1'b1;
                gnt     = SW'(idx);
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        cur_next      = cur_reg;
        last_next     = last_reg;
        req_addr_next = req_addr_reg;
        ba_addr_next  = ba_addr_reg;
        ba_rd_next    = ba_rd_reg;
        wcnt_next     = wcnt_reg;
        case (state_reg)
            IDLE: begin
                if (gnt_any) begin
                    cur_next      = gnt;
                    last_next     = gnt;
                    req_addr_next = addr_arr[gnt];
                    ba_addr_next  = waddr_arr[gnt];
                    ba_rd_next    = 1'b1;
                    state_next    = REQ;
                end
            end
            REQ: begin
                if (ba_ack) begin
                    ba_rd_next = 1'b0;
                    wcnt_next  = 2'd0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (ba_dok) begin
                    wcnt_next = (word_idx == 2'd3) ? 2'd3 : word_idx + 2'd1;
                end else if (ba_dst) begin
                    wcnt_next = 2'd0;
                end
                if (ba_rdy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cur_reg      <= '0;
            last_reg     <= SW'(SLOTS - 1);
            req_addr_reg <= '0;
            ba_addr_reg  <= '0;
            ba_rd_reg    <= 1'b0;
            wcnt_reg     <= 2'd0;
        end else begin
            state_reg    <= state_next;
            cur_reg      <= cur_next;
            last_reg     <= last_next;
            req_addr_reg <= req_addr_next;
            ba_addr_reg  <= ba_addr_next;
            ba_rd_reg    <= ba_rd_next;
            wcnt_reg     <= wcnt_next;
        end
    end

    assign ba_addr = ba_addr_reg;
    assign ba_rd   = ba_rd_reg;

endmodule

// File: tb/tb_jtvigil_romarb.sv
// Bench for jtvigil_romarb: an 8-bit round-robin instance (a_*) and a 32-bit fixed-priority instance (b_*).
module tb_jtvigil_romarb;
    localparam logic [87:0] OFFS = {22'h30000, 22'h20000, 22'h10000, 22'h00000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [3:0]   a_cs, a_ok, b_cs, b_ok;
    logic [71:0]  a_addr, b_addr;
    logic [31:0]  a_sd;
    logic [127:0] b_sd;
    logic [21:0]  a_ba, b_ba;
    logic         a_rd, a_ack, a_dst, a_dok, a_rdy;
    logic         b_rd, b_ack, b_dst, b_dok, b_rdy;
    logic [15:0]  a_dr, b_dr;

    jtvigil_romarb #(.SLOTS(4), .AW(18), .DW(8), .RR(1), .OFFSET(OFFS)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .slot_cs(a_cs), .slot_addr(a_addr), .slot_ok(a_ok),
        .slot_data(a_sd), .ba_addr(a_ba), .ba_rd(a_rd), .ba_ack(a_ack), .ba_dst(a_dst),
        .ba_dok(a_dok), .ba_rdy(a_rdy), .data_read(a_dr));

    jtvigil_romarb #(.SLOTS(4), .AW(18), .DW(32), .RR(0), .OFFSET(OFFS)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .slot_cs(b_cs), .slot_addr(b_addr), .slot_ok(b_ok),
        .slot_data(b_sd), .ba_addr(b_ba), .ba_rd(b_rd), .ba_ack(b_ack), .ba_dst(b_dst),
        .ba_dok(b_dok), .ba_rdy(b_rdy), .data_read(b_dr));

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int          slot;
        logic [21:0] ba;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int          slot;
        logic [17:0] addr;
        logic [15:0] word;
        logic [21:0] ba;
        logic [7:0]  data;
        int          ack_dly;
        logic        hit;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic push_exp(input int s, input logic [21:0] ba, input logic [31:0] d);
        exp_t e;
        e.slot = s;
        e.ba   = ba;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Answers one request on bank A: optional ack delay, optional slot address change after ack
    task automatic serve_a(input logic [15:0] w, input int ack_dly, input logic exp_ok,
                           input int chg, output int waited);
        exp_t e;
        waited = 0;
        while (a_rd !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (a_rd !== 1'b1) begin
            check("a_rd_timeout", 64'd0, 64'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            check("a_scoreboard_empty", 64'd0, 64'd1);
            return;
        end
        e = exp_q.pop_front();
        check("a_ba_addr", a_ba, e.ba);
        repeat (ack_dly) begin
            @(negedge clk);
            check("a_rd_hold", a_rd, 1);
            check("a_ba_hold", a_ba, e.ba);
        end
        a_ack = 1'b1;
        @(negedge clk);
        a_ack = 1'b0;
        check("a_rd_drop", a_rd, 0);
        if (chg >= 0) a_addr[e.slot*18 +: 18] = 18'(chg);
        @(negedge clk);
        a_dst = 1'b1; a_dok = 1'b1; a_rdy = 1'b1; a_dr = w;
        #1 check("a_ok_before_rdy", a_ok[e.slot], 0);
        @(negedge clk);
        a_dst = 1'b0; a_dok = 1'b0; a_rdy = 1'b0;
        #1 check("a_ok_after_rdy", a_ok[e.slot], exp_ok);
        check("a_slot_data", a_sd[e.slot*8 +: 8], e.data[7:0]);
        $display("A burst slot %0d ba_addr %06h word %04h ok %0b data %02h",
                 e.slot, e.ba, w, a_ok[e.slot], a_sd[e.slot*8 +: 8]);
    endtask

    // mode 0: dst+dok w0 then dok w1+rdy; mode 1: dst+dok w0+rdy; mode 2: stray dok, dst, then mode-0 words
    task automatic serve_b(input logic [15:0] w0, input logic [15:0] w1, input int mode,
                           input int chg0, input logic exp_ok, output int waited);
        exp_t e;
        waited = 0;
        while (b_rd !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (b_rd !== 1'b1) begin
            check("b_rd_timeout", 64'd0, 64'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            check("b_scoreboard_empty", 64'd0, 64'd1);
            return;
        end
        e = exp_q.pop_front();
        check("b_ba_addr", b_ba, e.ba);
        b_ack = 1'b1;
        @(negedge clk);
        b_ack = 1'b0;
        check("b_rd_drop", b_rd, 0);
        if (mode == 2) begin
            b_dok = 1'b1; b_dr = 16'h9999;
            @(negedge clk);
            b_dok = 1'b0; b_dst = 1'b1;
            @(negedge clk);
            b_dst = 1'b0;
        end
        b_dst = (mode != 2); b_dok = 1'b1; b_dr = w0; b_rdy = (mode == 1);
        if (mode != 1) begin
            @(negedge clk);
            b_dst = 1'b0; b_dr = w1; b_rdy = 1'b1;
        end
        if (chg0 >= 0) b_addr[17:0] = 18'(chg0);
        #1 check("b_ok_before_rdy", b_ok[e.slot], 0);
        @(negedge clk);
        b_dst = 1'b0; b_dok = 1'b0; b_rdy = 1'b0;
        #1 check("b_ok_after_rdy", b_ok[e.slot], exp_ok);
        check("b_slot_data", b_sd[e.slot*32 +: 32], e.data);
        $display("B burst slot %0d ba_addr %06h ok %0b data %08h",
                 e.slot, e.ba, b_ok[e.slot], b_sd[e.slot*32 +: 32]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        vec_t v;
        exp_t e;
        int   w;
        int   n;

        vecs[0] = '{1, 18'h00021, 16'h3C7E, 22'h010010, 8'h3C, 0, 1'b0};
        vecs[1] = '{2, 18'h00100, 16'h1234, 22'h020080, 8'h34, 2, 1'b0};
        vecs[2] = '{3, 18'h3FFFF, 16'hBEEF, 22'h04FFFF, 8'hBE, 1, 1'b0};
        vecs[3] = '{0, 18'h00000, 16'h00FF, 22'h000000, 8'hFF, 0, 1'b0};
        vecs[4] = '{1, 18'h00021, 16'h0000, 22'h000000, 8'h3C, 0, 1'b1};
        vecs[5] = '{3, 18'h3FFFF, 16'h0000, 22'h000000, 8'hBE, 0, 1'b1};

        rst_n = 1'b0;
        a_cs = '0; a_addr = '0; a_ack = 0; a_dst = 0; a_dok = 0; a_rdy = 0; a_dr = '0;
        b_cs = '0; b_addr = '0; b_ack = 0; b_dst = 0; b_dok = 0; b_rdy = 0; b_dr = '0;
        repeat (3) @(negedge clk);
        check("rst_a_rd", a_rd, 0);
        check("rst_a_ba_addr", a_ba, 0);
        check("rst_a_ok", a_ok, 0);
        check("rst_a_data", a_sd, 0);
        check("rst_b_rd", b_rd, 0);
        check("rst_b_data", b_sd[63:0], 0);
        rst_n = 1'b1;
        @(negedge clk);

        // All four slots miss at once: served 0,1,2,3
        a_cs = 4'hF;
        for (int s = 0; s < 4; s++) begin
            a_addr[s*18 +: 18] = 18'h10;
            push_exp(s, 22'(s << 16) | 22'h8, 32'h5A);
        end
        for (int s = 0; s < 4; s++) begin
            serve_a(16'hA55A, 0, 1'b1, -1, w);
            check("rr_rd_latency", 64'(w), 64'd1);
        end
        check("rr_all_ok", a_ok, 4'hF);
        check("rr_all_data", a_sd, 32'h5A5A5A5A);
        a_cs = '0;
        @(negedge clk);

        // After granting slot 1, slots 0 and 2 together: round-robin picks 2 first
        a_cs = 4'b0010; a_addr[18 +: 18] = 18'h30;
        push_exp(1, 22'h010018, 32'h02);
        serve_a(16'h0102, 1, 1'b1, -1, w);
        a_cs = '0;
        @(negedge clk);
        a_cs = 4'b0101; a_addr[0 +: 18] = 18'h30; a_addr[36 +: 18] = 18'h31;
        push_exp(2, 22'h020018, 32'h7F);
        push_exp(0, 22'h000018, 32'h0D);
        serve_a(16'h7F80, 0, 1'b1, -1, w);
        serve_a(16'h0C0D, 0, 1'b1, -1, w);
        a_cs = '0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            a_cs = 4'(1 << v.slot);
            a_addr[v.slot*18 +: 18] = v.addr;
            if (v.hit) begin
                #1 check("tbl_hit_ok", a_ok[v.slot], 1);
                check("tbl_hit_data", a_sd[v.slot*8 +: 8], v.data);
                @(negedge clk);
                check("tbl_hit_no_rd", a_rd, 0);
            end else begin
                push_exp(v.slot, v.ba, {24'h0, v.data});
                #1 check("tbl_miss_ok_low", a_ok[v.slot], 0);
                serve_a(v.word, v.ack_dly, 1'b1, -1, w);
                check("tbl_rd_latency", 64'(w), 64'd1);
            end
            a_cs = '0;
            @(negedge clk);
        end

        // Cache hit after cs drop, then a miss on a new address
        a_cs = 4'b0001; a_addr[0 +: 18] = 18'h7;
        push_exp(0, 22'h000003, 32'h77);
        serve_a(16'h7788, 0, 1'b1, -1, w);
        a_cs = '0;
        @(negedge clk);
        check("hit_cs_low_ok", a_ok[0], 0);
        a_cs = 4'b0001;
        #1 check("hit_same_cycle_ok", a_ok[0], 1);
        check("hit_data", a_sd[7:0], 8'h77);
        @(negedge clk);
        check("hit_no_rd", a_rd, 0);
        a_addr[0 +: 18] = 18'h8;
        #1 check("miss_same_cycle_ok", a_ok[0], 0);
        push_exp(0, 22'h000004, 32'h55);
        serve_a(16'h4455, 0, 1'b1, -1, w);
        check("miss_rd_latency", 64'(w), 64'd1);
        a_cs = '0;
        @(negedge clk);

        // Address change 7 -> 9 after ack: fill completes under tag 7
        a_cs = 4'b0010; a_addr[18 +: 18] = 18'h7;
        push_exp(1, 22'h010003, 32'h55);
        serve_a(16'h5566, 0, 1'b0, 9, w);
        a_addr[18 +: 18] = 18'h7;
        #1 check("chg_old_tag_hit", a_ok[1], 1);
        @(negedge clk);
        check("chg_no_rd_on_hit", a_rd, 0);
        a_addr[18 +: 18] = 18'h9;
        #1 check("chg_new_addr_ok_low", a_ok[1], 0);
        push_exp(1, 22'h010004, 32'h99);
        serve_a(16'h99AA, 0, 1'b1, -1, w);
        check("chg_rd_latency", 64'(w), 64'd1);
        a_cs = '0;
        @(negedge clk);

        // Reset between ba_dst and ba_rdy
        a_cs = 4'b0100; a_addr[36 +: 18] = 18'h44;
        push_exp(2, 22'h020022, 32'h0);
        n = 0;
        while (a_rd !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rst_burst_rd", a_rd, 1);
        e = exp_q.pop_front();
        check("rst_burst_ba_addr", a_ba, e.ba);
        a_ack = 1'b1;
        @(negedge clk);
        a_ack = 1'b0; a_dst = 1'b1; a_dok = 1'b1; a_dr = 16'h7777;
        @(negedge clk);
        a_dst = 1'b0; a_dok = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; a_rdy = 1'b1;
        #1 check("midrst_rd", a_rd, 0);
        check("midrst_ok", a_ok, 0);
        check("midrst_data", a_sd, 0);
        check("midrst_ba_addr", a_ba, 0);
        @(negedge clk);
        a_rdy = 1'b0;
        #1 check("late_rdy_ignored", a_ok[2], 0);
        check("fresh_rd", a_rd, 1);
        push_exp(2, 22'h020022, 32'h21);
        serve_a(16'h4321, 0, 1'b1, -1, w);
        a_cs = '0;
        @(negedge clk);

        // 32-bit slots: two-word fill, one-word fill, ba_dst restarting the word count
        b_cs = 4'b0001; b_addr[0 +: 18] = 18'h5;
        push_exp(0, 22'h00000A, 32'hABCD1234);
        serve_b(16'h1234, 16'hABCD, 0, -1, 1'b1, w);
        check("b_rd_latency", 64'(w), 64'd1);
        b_cs = '0;
        @(negedge clk);
        b_cs = 4'b0010; b_addr[18 +: 18] = 18'h3;
        push_exp(1, 22'h010006, 32'h00001111);
        serve_b(16'h1111, 16'h0000, 1, -1, 1'b1, w);
        b_cs = '0;
        @(negedge clk);
        b_cs = 4'b0100; b_addr[36 +: 18] = 18'h10;
        push_exp(2, 22'h020020, 32'h33332222);
        serve_b(16'h2222, 16'h3333, 2, -1, 1'b1, w);
        b_cs = '0;
        @(negedge clk);

        // Fixed priority: slot 0 keeps missing and starves slot 3 until it hits
        b_cs = 4'b1001; b_addr[0 +: 18] = 18'h0; b_addr[54 +: 18] = 18'h1;
        push_exp(0, 22'h000000, 32'hA0A0B0B0);
        push_exp(0, 22'h000004, 32'hC0C0D0D0);
        push_exp(0, 22'h000000, 32'hE0E0F0F0);
        push_exp(3, 22'h030002, 32'h12345678);
        serve_b(16'hB0B0, 16'hA0A0, 0, 2, 1'b0, w);
        serve_b(16'hD0D0, 16'hC0C0, 0, 0, 1'b0, w);
        serve_b(16'hF0F0, 16'hE0E0, 0, -1, 1'b1, w);
        serve_b(16'h5678, 16'h1234, 0, -1, 1'b1, w);
        check("fp_final_ok", b_ok, 4'b1001);
        b_cs = '0;
        @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
